// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: picks the next fetch address from return, jump, branch
// or sequential flow, presents it on a valid/ready fetch port, and keeps a return-address stack.
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Stall,
    input  logic                         BranchTaken,
    input  logic [15:0]                  PCBranch,
    input  logic                         Jump,
    input  logic [15:0]                  JumpTarget,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic                         FetchReady,
    output logic                         FetchValid,
    output logic [15:0]                  PC,
    output logic [15:0]                  PCPlus1,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasOverflow,
    output logic                         RasUnderflow,
    output logic                         state_dbg
);

    // Fetch handshake: FetchValid/PC form a request; it is accepted on a rising
    // edge where FetchValid && FetchReady. While unaccepted, PC stays stable unless
    // a redirect arrives, which abandons the pending request.

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [15:0]     pc_plus1;
    logic [15:0]     ras_mem [RAS_DEPTH];
    logic [AW-1:0]   sp_q, sp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push;
    logic            redirect;
    logic [15:0]     target;
    logic [15:0]     ras_top;
    logic            ras_empty;
    logic            ras_full;

    assign pc_plus1  = pc_q + 16'd1;
    // sp_q points at the next free slot; when full it is also the oldest entry.
    assign ras_top   = ras_mem[sp_q - 1'b1];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        redirect = 1'b0;
        target   = pc_plus1;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!Stall) begin
                    if (Ret) begin
                        redirect = 1'b1;
                        if (ras_empty) begin
                            target = pc_plus1;
                            unf_d  = 1'b1;
                        end else begin
                            target = ras_top;
                            sp_d   = sp_q - 1'b1;
                            cnt_d  = cnt_q - 1'b1;
                        end
                    end else if (Jump) begin
                        redirect = 1'b1;
                        target   = JumpTarget;
                        if (Call) begin
                            push = 1'b1;
                            sp_d = sp_q + 1'b1;
                            if (ras_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end else if (BranchTaken) begin
                        redirect = 1'b1;
                        target   = PCBranch;
                    end

                    if (redirect) begin
                        pc_d = target;
                    end else if (FetchReady) begin
                        pc_d = pc_plus1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            sp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push) begin
                ras_mem[sp_q] <= pc_plus1;
            end
        end
    end

    assign FetchValid   = (state_q == RUN);
    assign PC           = pc_q;
    assign PCPlus1      = pc_plus1;
    assign RasCount     = cnt_q;
    assign RasOverflow  = ovf_q;
    assign RasUnderflow = unf_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed vector table for the listed corner cases,
// then randomized traffic against a queue-based reference of the PC/RAS rules.
module tb_pc_fetch_sequencer;

    localparam logic [15:0] RV    = 16'h0010;
    localparam int          DEPTH = 4;
    localparam int          W     = 38;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] pcb;
        logic        jump;
        logic [15:0] jt;
        logic        call;
        logic        ret;
        logic        frdy;
        logic [15:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] PCBranch = '0;
    logic        Jump = 1'b0;
    logic [15:0] JumpTarget = '0;
    logic        Call = 1'b0;
    logic        Ret = 1'b0;
    logic        FetchReady = 1'b0;
    logic        FetchValid;
    logic [15:0] PC;
    logic [15:0] PCPlus1;
    logic [2:0]  RasCount;
    logic        RasOverflow;
    logic        RasUnderflow;
    logic        state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    vec_t tbl[$];

    // Reference state: stack is a queue, newest entry at the back.
    logic [15:0] m_pc;
    bit          m_run;
    bit          m_ovf;
    bit          m_unf;
    logic [15:0] m_ras[$];

    pc_fetch_sequencer #(
        .RESET_VEC (RV),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .PCBranch     (PCBranch),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .Call         (Call),
        .Ret          (Ret),
        .FetchReady   (FetchReady),
        .FetchValid   (FetchValid),
        .PC           (PC),
        .PCPlus1      (PCPlus1),
        .RasCount     (RasCount),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    function automatic logic [W-1:0] pack(input logic fv, input logic [15:0] pc,
                                          input logic [2:0] cnt, input logic ovf, input logic unf);
        logic [15:0] p1;
        p1 = pc + 16'd1;
        return {fv, pc, p1, cnt, ovf, unf};
    endfunction

    function automatic vec_t mk(input logic stall, input logic br, input logic [15:0] pcb,
                                input logic jump, input logic [15:0] jt, input logic call,
                                input logic ret, input logic frdy, input logic [15:0] e_pc,
                                input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.stall = stall; v.br = br; v.pcb = pcb; v.jump = jump; v.jt = jt;
        v.call = call; v.ret = ret; v.frdy = frdy;
        v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic check(input string what, input logic [W-1:0] exp);
        logic [W-1:0] act;
        act = {FetchValid, PC, PCPlus1, RasCount, RasOverflow, RasUnderflow};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got fv=%b pc=%h pc1=%h cnt=%0d ovf=%b unf=%b, want fv=%b pc=%h pc1=%h cnt=%0d ovf=%b unf=%b",
                     what, act[37], act[36:21], act[20:5], act[4:2], act[1], act[0],
                     exp[37], exp[36:21], exp[20:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input vec_t v);
        Stall       = v.stall;
        BranchTaken = v.br;
        PCBranch    = v.pcb;
        Jump        = v.jump;
        JumpTarget  = v.jt;
        Call        = v.call;
        Ret         = v.ret;
        FetchReady  = v.frdy;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 3'd0, 0, 0);
        drive(v);
    endtask

    // Reset with checks while held and right after release (still booting).
    task automatic reset_and_release();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("reset_held", pack(0, RV, 3'd0, 0, 0));
        rst_n = 1'b1;
        #1;
        check("boot_valid_low", pack(0, RV, 3'd0, 0, 0));
        m_pc = RV; m_run = 0; m_ovf = 0; m_unf = 0;
        m_ras.delete();
    endtask

    function automatic void model_step(input vec_t v);
        logic [15:0] nxt;
        nxt = m_pc + 16'd1;
        if (!m_run) begin
            m_run = 1;
        end else if (!v.stall) begin
            if (v.ret) begin
                if (m_ras.size() == 0) begin
                    m_unf = 1;
                    m_pc  = nxt;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (v.jump) begin
                if (v.call) begin
                    m_ras.push_back(nxt);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1;
                    end
                end
                m_pc = v.jt;
            end else if (v.br) begin
                m_pc = v.pcb;
            end else if (v.frdy) begin
                m_pc = nxt;
            end
        end
    endfunction

    initial begin
        vec_t v;
        string nm;

        // stall br pcb jump jt call ret frdy | pc cnt ovf unf
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0777, 1, 0, 1, 16'h0010, 3'd0, 0, 0)); // boot ignores inputs
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0011, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0011, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0012, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0005, 0, 16'h0000, 0, 0, 1, 16'h0012, 3'd0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0005, 0, 16'h0000, 0, 0, 0, 16'h0005, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h00FF, 0, 0, 0, 16'h00FF, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0400, 1, 0, 0, 16'h0400, 3'd1, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0300, 1, 16'h0200, 0, 1, 1, 16'h0100, 3'd0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0300, 1, 16'h0200, 0, 0, 1, 16'h0200, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0010, 0, 0, 0, 16'h0010, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0020, 1, 0, 0, 16'h0020, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0030, 1, 0, 1, 16'h0030, 3'd2, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0040, 1, 0, 0, 16'h0040, 3'd3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0050, 1, 0, 1, 16'h0050, 3'd4, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0060, 1, 0, 0, 16'h0060, 3'd4, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0051, 3'd3, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0041, 3'd2, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0031, 3'd1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0021, 3'd0, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0022, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h0023, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h1000, 1, 0, 0, 16'h1000, 3'd1, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h2000, 1, 1, 1, 16'h0024, 3'd0, 1, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0024, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 3'd0, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h1234, 0, 0, 0, 16'h1234, 3'd0, 1, 1));

        reset_and_release();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            exp_q.push_back(pack(1, tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_unf));
            @(negedge clk);
            nm = $sformatf("tbl[%0d]", i);
            check(nm, exp_q.pop_front());
        end

        // Async reset away from any clock edge must take effect at once.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcycle", pack(0, RV, 3'd0, 0, 0));

        reset_and_release();

        for (int i = 0; i < 2000; i++) begin
            v.stall = ($urandom_range(0, 9) < 2);
            v.ret   = ($urandom_range(0, 99) < 15);
            v.jump  = ($urandom_range(0, 99) < 25);
            v.call  = ($urandom_range(0, 1) == 1);
            v.br    = ($urandom_range(0, 99) < 20);
            v.frdy  = ($urandom_range(0, 9) < 7);
            v.pcb   = 16'($urandom);
            v.jt    = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            drive(v);
            model_step(v);
            exp_q.push_back(pack(m_run, m_pc, 3'(m_ras.size()), m_ovf, m_unf));
            @(negedge clk);
            nm = $sformatf("rand[%0d]", i);
            check(nm, exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
